tiny_soc_mem_router: RTL and testbench
======================================

// Module: tiny_soc_mem_router
// PURPOSE
//   Memory/MMIO front end for the tiny SoC top. It takes one core-side request
//   channel and decodes it into NumBanks single-port SRAM banks (relocated from
//   MemBase) or a write-only MMIO channel. It has a configurable read-return
//   pipeline and converts byte strobes to bit masks. MMIO reads and
//   out-of-map accesses are reported as a sticky error instead of being
//   asserted; a write to StopAddr halts the port.
// PARAMETERS
//   AddrWidth     32            core address width (bytes)
//   DataWidth     64            data width; StrbWidth = DataWidth/8
//   MMIOAddrWidth 31            MMIO address width; mmio_addr_o = addr_i[MMIOAddrWidth-1:0]
//   NumBanks      2             SRAM banks, power of two, >=1
//   BankWords     1<<19         words per bank, power of two
//   MemBase       32'h8000_0000 byte address of bank 0 word 0
//   ReadLatency   1             cycles from accepted read to rvalid_o, >=1
//   StopAddr      32'h0000_1000 MMIO byte address of the halt register
// PORTS
//   clk_i          in  1                   clock
//   rst_i          in  1                   async reset, active-high
//   clear_i        in  1                   sync: leave HALTED/ERROR, clear err_*
//   req_i          in  1                   core request
//   we_i           in  1                   1=write, 0=read
//   addr_i         in  AddrWidth           byte address
//   wdata_i        in  DataWidth           write data
//   strb_i         in  StrbWidth           byte strobes
//   gnt_o          out 1                   request accepted this cycle
//   rvalid_o       out 1                   read data valid
//   rdata_o        out DataWidth           read data
//   bank_req_o     out NumBanks            one-hot bank enable
//   bank_we_o      out 1                   bank write enable
//   bank_addr_o    out log2(BankWords)     word address within bank
//   bank_wdata_o   out DataWidth           bank write data
//   bank_wmask_o   out DataWidth           bit mask, bit i = strb_i[i/8]
//   bank_rdata_i   in  NumBanks*DataWidth  bank read data, 1 cycle after bank_req_o
//   mmio_req_o     out 1                   MMIO write strobe
//   mmio_addr_o    out MMIOAddrWidth       MMIO byte address
//   mmio_wdata_o   out DataWidth           MMIO write data
//   mmio_strb_o    out StrbWidth           MMIO strobes
//   halted_o       out 1                   state==HALTED
//   err_o          out 1                   state==ERROR
//   err_addr_o     out AddrWidth           address of the first faulting request
//   mmio_wr_cnt_o  out 32                  accepted MMIO writes, saturating
// BEHAVIOUR
//   - Reset: state RUN; all outputs 0; pipeline valids 0; counter 0.
//   - FSM RUN/HALTED/ERROR. gnt_o = req_i & state==RUN & !clear_i.
//     The bank and MMIO outputs are combinational from the request, gated by gnt_o.
//   - Decode (offset = addr_i - MemBase, word = offset >> log2(StrbWidth)):
//     * addr_i < MemBase: MMIO. A write drives mmio_req_o and increments the
//       counter. A read is an error.
//     * addr_i >= MemBase and word < NumBanks*BankWords: bank word/BankWords,
//       bank_addr_o = word % BankWords.
//     * Otherwise it is an error (out of map).
//   - Error on a granted request: no bank/MMIO strobe, no rvalid_o; next
//     state ERROR; err_addr_o <= addr_i. Only the first error is captured.
//   - A granted MMIO write to StopAddr with wdata_i[0]=1 is performed and
//     counted. The next state is HALTED.
//   - HALTED/ERROR: gnt_o=0; reads already in flight still return.
//   - clear_i: next state RUN, err_addr_o<=0; counter kept. It overrides a
//     same-cycle error/halt transition.
//   - Read return: the bank select and valid are delayed ReadLatency-1 register
//     stages after the bank's 1-cycle latency. rdata_o is the selected bank
//     word and is held between valids. Back-to-back reads: one per cycle.
//   - Counter saturates at 32'hFFFF_FFFF.
//   - Reset mid-read: pending rvalid_o is dropped.
// TESTING
//   - Write 0x1122..88 strb 8'h0F to 0x8000_0008, then read it.
//     -> bank_req_o=2'b01 and addr 1; wmask=64'h0000_0000_FFFF_FFFF;
//     rvalid_o ReadLatency cycles later with the low 32 bits written.
//   - Read 0x8040_0000 (NumBanks=2, BankWords=1<<19) -> bank_req_o=2'b10,
//     bank_addr_o=0. Read 0x8080_0000 -> err_o=1, err_addr_o=0x8080_0000,
//     no strobe.
//   - MMIO read to 0x1000_0000 -> err_o=1; next req gnt_o=0; clear_i -> RUN,
//     err_addr_o=0.
//   - 3 MMIO writes then write 1 to StopAddr -> mmio_wr_cnt_o=4, halted_o=1,
//     further req not granted.
//   - ReadLatency=3, 4 back-to-back reads to alternating banks -> 4 rvalid_o
//     pulses on consecutive cycles starting 3 cycles later, data in order.
//   - Assert rst_i while 2 reads are in flight -> rvalid_o never rises;
//     all outputs 0.

Source files
------------

// File: rtl/tiny_soc_mem_router.sv
// Memory/MMIO front end: decodes one core request channel into NumBanks
// single-port SRAM banks above MemBase or a write-only MMIO channel below it.
// It also returns bank read data through a configurable pipeline and tracks
// halt and error conditions.
module tiny_soc_mem_router #(
  parameter int                   AddrWidth     = 32,
  parameter int                   DataWidth     = 64,
  parameter int                   MMIOAddrWidth = 31,
  parameter int                   NumBanks      = 2,
  parameter int                   BankWords     = 1 << 19,
  parameter logic [AddrWidth-1:0] MemBase       = 32'h8000_0000,
  parameter int                   ReadLatency   = 1,
  parameter logic [AddrWidth-1:0] StopAddr      = 32'h0000_1000,
  localparam int                  StrbWidth     = DataWidth / 8,
  localparam int                  BankAw        = $clog2(BankWords)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [AddrWidth-1:0]          addr_i,
  input  logic [DataWidth-1:0]          wdata_i,
  input  logic [StrbWidth-1:0]          strb_i,
  output logic                          gnt_o,
  output logic                          rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic [NumBanks-1:0]           bank_req_o,
  output logic                          bank_we_o,
  output logic [BankAw-1:0]             bank_addr_o,
  output logic [DataWidth-1:0]          bank_wdata_o,
  output logic [DataWidth-1:0]          bank_wmask_o,
  input  logic [NumBanks*DataWidth-1:0] bank_rdata_i,
  output logic                          mmio_req_o,
  output logic [MMIOAddrWidth-1:0]      mmio_addr_o,
  output logic [DataWidth-1:0]          mmio_wdata_o,
  output logic [StrbWidth-1:0]          mmio_strb_o,
  output logic                          halted_o,
  output logic                          err_o,
  output logic [AddrWidth-1:0]          err_addr_o,
  output logic [31:0]                   mmio_wr_cnt_o
);

  localparam int OffW = $clog2(StrbWidth);
  localparam int SelW = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam logic [AddrWidth:0] MapWords =
    (AddrWidth+1)'(longint'(NumBanks) * longint'(BankWords));

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_ERROR} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   err_addr_q, err_addr_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [ReadLatency-1:0] vld_q, vld_d;
  logic [SelW-1:0]        sel_q, sel_d;
  logic [DataWidth-1:0]   hold_q, hold_d;

  logic [AddrWidth-1:0]   offset, word;
  logic                   is_mmio, in_map, bank_hit, rd_issue, acc_err, halt_req;
  logic [SelW-1:0]        bank_idx;
  logic [DataWidth-1:0]   bank_word, ret_data;

  // Address decode: MMIO below MemBase, banks inside the map, error beyond it
  assign offset   = addr_i - MemBase;
  assign word     = offset >> OffW;
  assign is_mmio  = addr_i < MemBase;
  assign in_map   = !is_mmio && ({1'b0, word} < MapWords);
  assign bank_idx = SelW'(word >> BankAw);

  assign gnt_o      = req_i & (state_q == ST_RUN) & ~clear_i;
  assign bank_hit   = gnt_o & in_map;
  assign rd_issue   = bank_hit & ~we_i;
  assign mmio_req_o = gnt_o & is_mmio & we_i;
  assign acc_err    = gnt_o & (is_mmio ? ~we_i : ~in_map);
  assign halt_req   = mmio_req_o & (addr_i == StopAddr) & wdata_i[0];

  // Bank and MMIO request outputs, zero unless the request is granted and routed there
  always_comb begin
    bank_req_o   = '0;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_wmask_o = '0;
    if (bank_hit) begin
      bank_req_o   = NumBanks'(1) << bank_idx;
      bank_we_o    = we_i;
      bank_addr_o  = word[BankAw-1:0];
      bank_wdata_o = wdata_i;
      for (int i = 0; i < DataWidth; i++) bank_wmask_o[i] = strb_i[i/8];
    end
  end

  // MMIO write channel payload
  always_comb begin
    mmio_addr_o  = '0;
    mmio_wdata_o = '0;
    mmio_strb_o  = '0;
    if (mmio_req_o) begin
      mmio_addr_o  = addr_i[MMIOAddrWidth-1:0];
      mmio_wdata_o = wdata_i;
      mmio_strb_o  = strb_i;
    end
  end

  // Next state: clear wins over a same-cycle error, error wins over halt
  always_comb begin
    state_d    = state_q;
    err_addr_d = err_addr_q;
    cnt_d      = cnt_q;
    if (mmio_req_o && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    if (clear_i) begin
      state_d    = ST_RUN;
      err_addr_d = '0;
    end else if (acc_err) begin
      state_d    = ST_ERROR;
      err_addr_d = addr_i;
    end else if (halt_req) begin
      state_d    = ST_HALTED;
    end
  end

  // Read return control: valid shift chain, bank select for the cycle data arrives
  assign bank_word = bank_rdata_i[sel_q*DataWidth +: DataWidth];
  assign rvalid_o  = vld_q[ReadLatency-1];
  assign rdata_o   = rvalid_o ? ret_data : hold_q;

  always_comb begin
    vld_d  = ReadLatency'({vld_q, rd_issue});
    sel_d  = rd_issue ? bank_idx : sel_q;
    hold_d = rvalid_o ? ret_data : hold_q;
  end

  // Bank word is captured the cycle it is valid, then delayed to line up with rvalid_o
  if (ReadLatency == 1) begin : g_direct
    assign ret_data = bank_word;
  end else begin : g_delay
    logic [DataWidth-1:0] dat_q [ReadLatency-1];
    logic [DataWidth-1:0] dat_d [ReadLatency-1];

    // Data stage shift
    always_comb begin
      dat_d[0] = bank_word;
      for (int k = 1; k < ReadLatency-1; k++) dat_d[k] = dat_q[k-1];
    end

    // Data registers carry no reset; validity comes from vld_q
    always_ff @(posedge clk_i) begin
      dat_q <= dat_d;
    end

    assign ret_data = dat_q[ReadLatency-2];
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      err_addr_q <= '0;
      cnt_q      <= '0;
      vld_q      <= '0;
      sel_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
    end
  end

  assign halted_o      = (state_q == ST_HALTED);
  assign err_o         = (state_q == ST_ERROR);
  assign err_addr_o    = err_addr_q;
  assign mmio_wr_cnt_o = cnt_q;

endmodule

// File: tb/tb_tiny_soc_mem_router.sv
// Randomized and directed bench for tiny_soc_mem_router against a flat-memory
// reference model with a queue of expected read returns.
module tb_tiny_soc_mem_router;

  localparam int          RL      = 3;
  localparam int          NB      = 2;
  localparam int          BW      = 1 << 19;
  localparam logic [31:0] MEMBASE = 32'h8000_0000;
  localparam logic [31:0] STOP    = 32'h0000_1000;

  logic          clk, rst_i, clear_i, req_i, we_i;
  logic [31:0]   addr_i;
  logic [63:0]   wdata_i;
  logic [7:0]    strb_i;
  logic          gnt_o, rvalid_o, bank_we_o, mmio_req_o, halted_o, err_o;
  logic [63:0]   rdata_o, bank_wdata_o, bank_wmask_o, mmio_wdata_o;
  logic [1:0]    bank_req_o;
  logic [18:0]   bank_addr_o;
  logic [127:0]  bank_rdata_i;
  logic [30:0]   mmio_addr_o;
  logic [7:0]    mmio_strb_o;
  logic [31:0]   err_addr_o, mmio_wr_cnt_o;

  tiny_soc_mem_router #(.ReadLatency(RL)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .strb_i(strb_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .bank_req_o(bank_req_o),
    .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o),
    .bank_wmask_o(bank_wmask_o), .bank_rdata_i(bank_rdata_i),
    .mmio_req_o(mmio_req_o), .mmio_addr_o(mmio_addr_o), .mmio_wdata_o(mmio_wdata_o),
    .mmio_strb_o(mmio_strb_o), .halted_o(halted_o), .err_o(err_o),
    .err_addr_o(err_addr_o), .mmio_wr_cnt_o(mmio_wr_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM banks seen by the DUT: 1-cycle read latency, bit-masked writes
  logic [63:0]  bank_rd [NB];
  logic [63:0]  sram [int unsigned];
  int unsigned  skey;
  logic [63:0]  sold;
  assign bank_rdata_i = {bank_rd[1], bank_rd[0]};
  initial begin bank_rd[0] = '0; bank_rd[1] = '0; end
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_req_o[b]) begin
        skey = (b << 24) | 32'(bank_addr_o);
        sold = sram.exists(skey) ? sram[skey] : 64'd0;
        if (bank_we_o) sram[skey] = (sold & ~bank_wmask_o) | (bank_wdata_o & bank_wmask_o);
        else           bank_rd[b] <= sold;
      end
    end
  end

  // Reference model: state 0=run 1=halted 2=error, flat word memory, read queue
  int           n_tests, n_fail, cyc, st;
  logic [31:0]  m_err_addr, m_cnt;
  logic [63:0]  m_last;
  logic [63:0]  ref_mem [longint unsigned];
  int           exp_due [$];
  logic [63:0]  exp_dat [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    st = 0; m_err_addr = '0; m_cnt = '0; m_last = '0;
    exp_due.delete(); exp_dat.delete();
  endtask

  // One cycle: drive after the edge, check at the falling edge, advance the model
  task automatic step(input logic rq, input logic w, input logic [31:0] a,
                      input logic [63:0] wd, input logic [7:0] sb, input logic clr);
    logic g, mm, inmap, er, hlt, ev;
    longint unsigned wi;
    logic [1:0]  ebr;
    logic [18:0] eba;
    logic [63:0] emask, ed, old;
    req_i = rq; we_i = w; addr_i = a; wdata_i = wd; strb_i = sb; clear_i = clr;
    g     = rq && (st == 0) && !clr && !rst_i;
    mm    = a < MEMBASE;
    wi    = mm ? 64'd0 : (longint'(a) - longint'(MEMBASE)) / 8;
    inmap = !mm && (wi < longint'(NB) * longint'(BW));
    er    = g && (mm ? !w : !inmap);
    for (int i = 0; i < 64; i++) emask[i] = sb[i/8];
    ebr   = (g && inmap) ? 2'(1 << (wi / BW)) : 2'b00;
    eba   = (g && inmap) ? 19'(wi % BW) : 19'd0;
    ev    = (exp_due.size() > 0) && (exp_due[0] == cyc);
    ed    = ev ? exp_dat[0] : m_last;
    @(negedge clk);
    chk("gnt", gnt_o, g);
    chk("bank_req", bank_req_o, ebr);
    chk("bank_we", bank_we_o, g && inmap && w);
    chk("bank_addr", bank_addr_o, eba);
    chk("bank_wmask", bank_wmask_o, (g && inmap) ? emask : 64'd0);
    chk("bank_wdata", bank_wdata_o, (g && inmap) ? wd : 64'd0);
    chk("mmio_req", mmio_req_o, g && mm && w);
    chk("mmio_addr", mmio_addr_o, (g && mm && w) ? 64'(a[30:0]) : 64'd0);
    chk("mmio_wdata", mmio_wdata_o, (g && mm && w) ? wd : 64'd0);
    chk("mmio_strb", mmio_strb_o, (g && mm && w) ? 64'(sb) : 64'd0);
    chk("halted", halted_o, st == 1);
    chk("err", err_o, st == 2);
    chk("err_addr", err_addr_o, m_err_addr);
    chk("cnt", mmio_wr_cnt_o, m_cnt);
    chk("rvalid", rvalid_o, ev);
    chk("rdata", rdata_o, ed);
    if (ev) begin void'(exp_due.pop_front()); void'(exp_dat.pop_front()); m_last = ed; end
    if (!rst_i) begin
      if (g && inmap && !w) begin
        exp_due.push_back(cyc + RL);
        exp_dat.push_back(ref_mem.exists(wi) ? ref_mem[wi] : 64'd0);
      end
      if (g && inmap && w) begin
        old = ref_mem.exists(wi) ? ref_mem[wi] : 64'd0;
        ref_mem[wi] = (old & ~emask) | (wd & emask);
      end
      if (g && mm && w && (m_cnt != 32'hFFFF_FFFF)) m_cnt++;
      hlt = g && mm && w && (a == STOP) && wd[0];
      if (clr)      begin st = 0; m_err_addr = '0; end
      else if (er)  begin st = 2; m_err_addr = a; end
      else if (hlt) st = 1;
    end
    @(posedge clk); cyc++; #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 64'd0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    idle(2);
    rst_i = 1'b0;
  endtask

  logic [31:0] ra;
  logic        rw, rc;
  int          k;

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_i = 1'b1; clear_i = 0; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; strb_i = '0;
    model_reset();
    @(posedge clk); #1;
    idle(2);
    rst_i = 1'b0;
    idle(1);

    // Masked write then read back
    step(1, 1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'h0F, 0);
    step(1, 0, 32'h8000_0008, 64'd0, 8'h00, 0);
    idle(RL + 1);
    chk("rdata_lit", rdata_o, 64'h0000_0000_5566_7788);

    // Bank 1 base, then out-of-map error and clear
    step(1, 0, 32'h8040_0000, 64'd0, 8'h00, 0);
    step(1, 0, 32'h8080_0000, 64'd0, 8'h00, 0);
    idle(RL);
    chk("err_addr_lit", err_addr_o, 64'h8080_0000);
    step(1, 1, 32'h8000_0000, 64'd5, 8'hFF, 1);
    idle(1);

    // MMIO read is an error; next request not granted; clear
    step(1, 0, 32'h1000_0000, 64'd0, 8'h00, 0);
    step(1, 1, 32'h1000_0008, 64'd1, 8'hFF, 0);
    step(0, 0, 32'd0, 64'd0, 8'h00, 1);
    idle(1);

    // Three MMIO writes then halt
    do_reset();
    step(1, 1, 32'h0000_0100, 64'hA, 8'hFF, 0);
    step(1, 1, 32'h0000_0108, 64'hB, 8'h03, 0);
    step(1, 1, 32'h0000_0FF8, 64'hC, 8'h80, 0);
    step(1, 1, STOP, 64'd1, 8'h01, 0);
    step(1, 1, 32'h0000_0100, 64'hD, 8'hFF, 0);
    chk("cnt_lit", mmio_wr_cnt_o, 64'd4);
    chk("halted_lit", halted_o, 64'd1);
    step(0, 0, 32'd0, 64'd0, 8'h00, 1);

    // Back-to-back reads alternating banks
    step(1, 1, 32'h8000_0010, 64'hAAAA_0000_0000_0001, 8'hFF, 0);
    step(1, 1, 32'h8040_0010, 64'hBBBB_0000_0000_0002, 8'hFF, 0);
    step(1, 1, 32'h8000_0018, 64'hCCCC_0000_0000_0003, 8'hFF, 0);
    step(1, 1, 32'h8040_0018, 64'hDDDD_0000_0000_0004, 8'hFF, 0);
    step(1, 0, 32'h8000_0010, 64'd0, 8'h00, 0);
    step(1, 0, 32'h8040_0010, 64'd0, 8'h00, 0);
    step(1, 0, 32'h8000_0018, 64'd0, 8'h00, 0);
    step(1, 0, 32'h8040_0018, 64'd0, 8'h00, 0);
    idle(RL + 2);

    // Reset while two reads are in flight
    step(1, 0, 32'h8000_0010, 64'd0, 8'h00, 0);
    step(1, 0, 32'h8040_0018, 64'd0, 8'h00, 0);
    do_reset();
    idle(RL + 2);

    // Randomized traffic including map boundaries
    for (int n = 0; n < 500; n++) begin
      k  = $urandom_range(0, 19);
      rw = $urandom_range(0, 1);
      case (k)
        0, 1: begin ra = 32'h1000_0000 + 32'($urandom_range(0, 15)) * 8; rw = ($urandom_range(0, 3) != 0); end
        2:    ra = STOP;
        3:    ra = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF8 : 32'h8080_0000 + 32'($urandom_range(0, 7)) * 8;
        4: begin
          case ($urandom_range(0, 4))
            0: ra = 32'h807F_FFF8;
            1: ra = 32'h7FFF_FFF8;
            2: ra = 32'h8000_0000;
            3: ra = 32'h803F_FFF8;
            default: ra = 32'h8040_0000;
          endcase
        end
        default: ra = MEMBASE + 32'($urandom_range(0, 1)) * 32'h0040_0000
                      + 32'($urandom_range(0, 7)) * 8 + 32'($urandom_range(0, 7));
      endcase
      rc = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 4) != 0, rw, ra, {$urandom, $urandom}, 8'($urandom), rc);
    end
    idle(RL + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
